// File: rtl/bsg_wh_inject_pkg.sv
// Shared types and helpers for the wormhole injection arbiter.
//   wh_state_e  : arbiter FSM state (IDLE = between packets, BUSY = packet in flight)
//   wh_hdr_len  : pulls the body-flit count out of a header flit
package bsg_wh_inject_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } wh_state_e;

    // Widest flit the helper accepts; callers zero-extend into this.
    localparam int max_flit_width_lp = 512;

    // Header layout: [cord_width-1:0] destination, then len_width bits of length.
    function automatic logic [31:0] wh_hdr_len(input logic [max_flit_width_lp-1:0] flit,
                                               input int cord_width,
                                               input int len_width);
        logic [max_flit_width_lp-1:0] sh;
        logic [31:0] mask;
        sh   = flit >> cord_width;
        mask = (32'd1 << len_width) - 32'd1;
        return sh[31:0] & mask;
    endfunction

endpackage

// File: rtl/bsg_wh_inject_rr_arb.sv
// Combinational rotating-priority encoder.
//   req_i   : request vector
//   last_i  : index of the most recent winner; search starts at last_i+1 and wraps
//   grant_o : one-hot winner, zero when no request
module bsg_wh_inject_rr_arb #(
    parameter int num_req_p = 4,
    parameter int lg_req_p  = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0] req_i,
    input  logic [lg_req_p-1:0]  last_i,
    output logic [num_req_p-1:0] grant_o
);

    logic                found;
    logic [lg_req_p-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int off = 1; off <= num_req_p; off++) begin
            idx = lg_req_p'((int'(last_i) + off) % num_req_p);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_wormhole_inject_arbiter.sv
// Shares a router's local injection port between num_req_p requesters.
// Round-robin grants change only at packet boundaries so wormhole packets
// never interleave. Datapath is zero latency (pure mux).
//
// Ports:
//   clk_i, reset_n_i    : clock, asynchronous active-low reset
//   req_data_i/req_v_i  : per-requester flit and valid
//   req_ready_and_o     : per-requester ready; only the owner sees ready_and_i
//   data_o/v_o          : flit toward the router P port
//   ready_and_i         : router P-port ready
//   grant_o             : one-hot current owner (zero when idle and nobody valid)
//   busy_o              : a multi-flit packet is in flight
//   starve_o            : saturated starve flags (only with the macro below)
//
// Optional: define BSG_WH_INJECT_STARVE_GUARD_EN to add per-requester 8-bit
// starve counters; a saturated requester overrides round-robin at the next
// IDLE arbitration (lowest index wins ties).
module bsg_wormhole_inject_arbiter
    import bsg_wh_inject_pkg::*;
#(
    parameter int num_req_p    = 4,
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 8,
    parameter int len_width_p  = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [num_req_p-1:0][flit_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]                  req_v_i,
    output logic [num_req_p-1:0]                  req_ready_and_o,
    output logic [flit_width_p-1:0]               data_o,
    output logic                                  v_o,
    input  logic                                  ready_and_i,
    output logic [num_req_p-1:0]                  grant_o,
    output logic                                  busy_o
`ifdef BSG_WH_INJECT_STARVE_GUARD_EN
   ,output logic [num_req_p-1:0]                  starve_o
`endif
);

    localparam int lg_req_lp = $clog2(num_req_p);

    wh_state_e              state_r;
    logic [len_width_p-1:0] cnt_r;
    logic [len_width_p-1:0] hdr_len;
    logic [lg_req_lp-1:0]   last_r, owner_r, idle_owner, owner;
    logic [num_req_p-1:0]   rr_grant, idle_grant, grant;
    logic                   hs;

    bsg_wh_inject_rr_arb #(
        .num_req_p(num_req_p),
        .lg_req_p (lg_req_lp)
    ) rr_arb (
        .req_i  (req_v_i),
        .last_i (last_r),
        .grant_o(rr_grant)
    );

`ifdef BSG_WH_INJECT_STARVE_GUARD_EN
    logic [num_req_p-1:0][7:0] starve_cnt_r;
    logic [num_req_p-1:0]      starve_sat, starve_req, starve_grant;

    always_comb begin
        for (int i = 0; i < num_req_p; i++) starve_sat[i] = &starve_cnt_r[i];
    end

    assign starve_req = starve_sat & req_v_i;

    // Walk from the top down so the lowest saturated index is left standing.
    always_comb begin
        starve_grant = '0;
        for (int i = num_req_p-1; i >= 0; i--) begin
            if (starve_req[i]) starve_grant = num_req_p'(1) << i;
        end
    end

    assign idle_grant = (|starve_req) ? starve_grant : rr_grant;
    assign starve_o   = starve_sat;

    // Counters only move while arbitrating; a packet in flight freezes them.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve_cnt_r <= '0;
        end else if (state_r == IDLE) begin
            for (int i = 0; i < num_req_p; i++) begin
                if (idle_grant[i])
                    starve_cnt_r[i] <= '0;
                else if (req_v_i[i] && !starve_sat[i])
                    starve_cnt_r[i] <= starve_cnt_r[i] + 8'd1;
            end
        end
    end
`else
    assign idle_grant = rr_grant;
`endif

    always_comb begin
        idle_owner = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (idle_grant[i]) idle_owner = lg_req_lp'(i);
        end
    end

    assign owner = (state_r == BUSY) ? owner_r : idle_owner;
    assign grant = (state_r == BUSY) ? (num_req_p'(1) << owner_r) : idle_grant;

    // When idle with no valid requester, owner is 0 and req_v_i[0] is 0,
    // so v_o falls out low without a separate qualifier.
    assign v_o             = reset_n_i & req_v_i[owner];
    assign data_o          = reset_n_i ? req_data_i[owner] : '0;
    assign grant_o         = reset_n_i ? grant : '0;
    assign req_ready_and_o = (reset_n_i & ready_and_i) ? grant : '0;
    assign busy_o          = reset_n_i & (state_r == BUSY);

    assign hs      = v_o & ready_and_i;
    assign hdr_len = len_width_p'(wh_hdr_len(max_flit_width_lp'(req_data_i[owner]),
                                             cord_width_p, len_width_p));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            last_r  <= lg_req_lp'(num_req_p-1);
            owner_r <= '0;
        end else begin
            case (state_r)
                IDLE: if (hs) begin
                    if (hdr_len == '0) begin
                        last_r <= idle_owner;
                    end else begin
                        state_r <= BUSY;
                        cnt_r   <= hdr_len;
                        owner_r <= idle_owner;
                    end
                end
                BUSY: if (hs) begin
                    cnt_r <= cnt_r - len_width_p'(1);
                    // cnt_r==1 marks the tail; cnt_r never reaches 0 in BUSY.
                    if (cnt_r == len_width_p'(1)) begin
                        state_r <= IDLE;
                        last_r  <= owner_r;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bsg_wormhole_inject_arbiter.md
Name: bsg_wormhole_inject_arbiter

Overview:
- Shares the local (P) injection port of one bsg_wormhole_router between num_req_p on-chip requesters.
- Each requester presents a flit stream using ready-and-valid handshaking.
- Grants are round-robin and happen only at packet boundaries. A granted requester holds the port until its last flit is accepted, so wormhole packets never interleave.
- Sits between the tile-side clients and the router's P-port link input. The router link itself is unchanged.

Parameters:
- num_req_p, 4, number of requesters (>=2).
- flit_width_p, 32, flit width; must equal the router's flit_width_gp.
- cord_width_p, 8, width of the destination-coordinate field at header bits [cord_width_p-1:0].
- len_width_p, 4, width of the length field at header bits [cord_width_p+len_width_p-1:cord_width_p]. It holds the number of body flits after the header.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- req_data_i  in  num_req_p*flit_width_p  per-requester flit
- req_v_i  in  num_req_p  per-requester flit valid
- req_ready_and_o  out  num_req_p  per-requester ready (ready-and-valid)
- data_o  out  flit_width_p  flit to router P port
- v_o  out  1  flit valid to router
- ready_and_i  in  1  router P-port ready
- grant_o  out  num_req_p  one-hot current owner; zero when idle with no valid request
- busy_o  out  1  packet in flight (state BUSY)

Behaviour:
- Reset is asynchronous and active-low on reset_n_i. Clock is clk_i. All flops use posedge clk_i or negedge reset_n_i.
- While reset_n_i=0, outputs are forced: v_o=0, req_ready_and_o=0, grant_o=0, busy_o=0, data_o=0.
- Reset state: state_r=IDLE, cnt_r=0, last_r=num_req_p-1, so requester 0 has first priority.
- Datapath is zero latency and combinational: data_o=req_data_i[owner], v_o=req_v_i[owner], req_ready_and_o[owner]=ready_and_i. All other ready bits are 0.
- A handshake occurs when v_o && ready_and_i.
- IDLE state:
  - The owner is the round-robin winner among req_v_i. Priority starts at last_r+1 and wraps modulo num_req_p.
  - If no requester is valid, grant_o=0 and v_o=0.
  - Header handshake with len==0: stay in IDLE; last_r<=owner.
  - Header handshake with len>0: go to BUSY; cnt_r<=len; owner_r<=owner.
  - No handshake (router stalls): stay in IDLE; last_r is unchanged.
  - Re-arbitration while stalled is allowed. A requester must keep v asserted once raised, per ready-and-valid rules, but the grant may move to a higher-priority new arrival before acceptance.
- BUSY state:
  - owner=owner_r, and grant_o is held.
  - Each handshake decrements cnt_r.
  - The handshake with cnt_r==1 is the tail: go to IDLE; last_r<=owner_r.
  - A valid from any other requester is ignored; its ready stays 0.
  - A low req_v_i from the owner produces a bubble (v_o=0); no state change.
- busy_o=(state_r==BUSY).
- cnt_r is len_width_p bits and never underflows. A maximum len of 2^len_width_p-1 body flits is legal.
- Back-to-back operation: the cycle after a tail, IDLE arbitration runs with the updated last_r. A new header can be accepted in that cycle, giving zero dead cycles between packets.
- Reset asserted mid-packet aborts the packet and returns to the reset state. The remaining flits are not sent; the router is reset by the same domain.

Optional Feature:
- Macro: BSG_WH_INJECT_STARVE_GUARD_EN.
- With the macro defined:
  - Adds a starve counter per requester, width 8 bits.
  - A requester's counter increments each cycle it is valid in IDLE but not granted. It clears when that requester is granted.
  - If any counter reaches 255, that requester gets absolute priority at the next IDLE arbitration, overriding round-robin. Ties go to the lowest index.
  - Adds output starve_o (num_req_p bits), giving the saturated flags.
- Without the macro: pure round-robin, no counters, no starve_o port.

Decomposition:
- Package bsg_wh_inject_pkg holds:
  - state enum typedef, IDLE=1'b0, BUSY=1'b1;
  - a function extracting len from a header flit, given cord_width_p and len_width_p.
- One sub-module, bsg_wh_inject_rr_arb:
  - combinational rotate-priority encoder;
  - inputs: req vector and last_r;
  - outputs: one-hot grant.
  - The starve override, when enabled, is applied in the parent.

Test Plan:
- Single requester: req0 sends header len=2 plus 2 body flits with ready_and_i=1. Expect 3 consecutive v_o cycles, grant_o=0001 throughout, busy_o high for cycles 2-3, then IDLE.
- Round-robin: all 4 requesters continuously valid with len=0 packets. Expect grant order 0,1,2,3,0 on consecutive cycles.
- No interleave: req1 owns a len=3 packet and req0 raises valid mid-packet. Expect req_ready_and_o[0]=0 until req1's tail is accepted; req0 is granted the next cycle.
- Backpressure: drop ready_and_i for 5 cycles mid-packet. Expect data_o held, cnt_r unchanged, no flit loss, and the tail completing after ready returns.
- Reset mid-packet: pull reset_n_i low during body flit 2 of a len=5 packet. Expect immediate v_o=0, grant_o=0, busy_o=0; after release, requester 0 has priority.
- Starve guard enabled: hold req3 valid while req0-2 send back-to-back long packets (fed adversarially by the bench). Expect starve_o[3]=1 at count 255 and req3 granted at the next IDLE arbitration.
